branch_target_predictor: RTL
============================

// Module: branch_target_predictor
// PURPOSE
//  Direct-mapped branch target buffer with 2-bit saturating direction counters.
//  Supplies hit/taken/pred_PC to instr_fetch for the PC currently being fetched.
//  Trains from resolved-branch updates sent back by the execute stage.
//  Also counts resolved mispredictions for performance monitoring.
// PARAMETERS
//  ENTRIES   16  number of BTB entries (power of two)
//  INDEX_W   4   log2(ENTRIES); index = PC[INDEX_W+1:2], tag = PC[31:INDEX_W+2]
//  CNT_W     16  width of misprediction counter
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         asynchronous, active-low reset
//  PC           in   32        fetch-stage PC being looked up
//  hit          out  1         valid entry with matching tag exists for PC
//  taken        out  1         predicted taken (hit & counter[1])
//  pred_PC      out  32        stored target on hit, else 0
//  upd_valid    in   1         resolved control-flow instruction this cycle
//  upd_PC       in   32        PC of resolved branch
//  upd_taken    in   1         actual outcome
//  upd_target   in   32        actual target (valid when upd_taken)
//  upd_mispred  in   1         execute-stage flag: prediction was wrong
//  clear        in   1         synchronous invalidate of all entries
//  mispred_cnt  out  CNT_W     saturating count of upd_valid & upd_mispred
// BEHAVIOUR
//  - Reset (rst=0, async): all valid bits=0, counters=2'b01, targets=0,
//    mispred_cnt=0; hit=0, taken=0, pred_PC=0 while in reset.
//  - Lookup is combinational from PC and current table state (zero latency).
//    hit=valid[idx] & tag match; taken=hit & cnt[1]; pred_PC=hit?target:0.
//  - Update is written on rising clk when upd_valid=1; visible next cycle.
//  - Update, entry hits (valid & tag match upd_PC):
//    upd_taken=1: cnt=min(cnt+1,3), target<=upd_target.
//    upd_taken=0: cnt=max(cnt-1,0); target unchanged; entry stays valid.
//  - Update, entry misses: upd_taken=1 allocates/replaces: valid=1, tag,
//    target<=upd_target, cnt=2'b10 (weakly taken). upd_taken=0: no change.
//  - Same-cycle lookup and update to same index: lookup returns pre-update data.
//  - clear=1: all valid bits <= 0 next edge; counters reset to 2'b01;
//    clear wins over a simultaneous update; mispred_cnt not affected.
//  - mispred_cnt increments when upd_valid & upd_mispred; saturates at
//    all-ones (no wrap). upd_mispred ignored when upd_valid=0.
//  - PC[1:0] and upd_PC[1:0] ignored. Aliasing PCs with equal index and
//    different tag replace each other (direct-mapped, no LRU).
//  - rst asserted mid-operation clears table and counter immediately.
// TESTING
//  1 Reset: rst=0 then 1, PC=0x40 -> hit=0, taken=0, pred_PC=0, mispred_cnt=0.
//  2 Allocate: upd PC=0x40 taken target=0x100 -> next cycle PC=0x40 gives
//    hit=1, taken=1, pred_PC=0x100; PC=0x80 (same idx, tag 2) gives hit=0.
//  3 Counter hysteresis: after case 2, two not-taken updates at 0x40 ->
//    after first taken=0 (cnt 01), after second cnt 00, hit stays 1;
//    two taken updates -> taken=1 again; four taken -> cnt saturates at 11.
//  4 Not-taken miss: upd PC=0x44 taken=0 -> PC=0x44 still hit=0.
//  5 Simultaneous: clear=1 with upd PC=0x48 taken -> next cycle all hit=0;
//    lookup of 0x40 in same cycle as its update returns old target.
//  6 mispred_cnt: 3 cycles upd_valid&upd_mispred plus 1 with upd_valid=0
//    -> 3; force 0xFFFF then one more -> stays 0xFFFF; rst mid-run -> 0.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a saturating
// misprediction counter; combinational lookup, clocked training.
module branch_target_predictor #(
   parameter int ENTRIES = 16,
   parameter int INDEX_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      PC,
   output logic             hit,
   output logic             taken,
   output logic [31:0]      pred_PC,
   input  logic             upd_valid,
   input  logic [31:0]      upd_PC,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_mispred,
   input  logic             clear,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int TAG_W = 32 - INDEX_W - 2;

   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [31:0]      tgt_q   [ENTRIES];
   logic [1:0]       cnt_q   [ENTRIES];
   logic [CNT_W-1:0] mis_q;

   logic [INDEX_W-1:0] rd_idx;
   logic [TAG_W-1:0]   rd_tag;
   logic [INDEX_W-1:0] wr_idx;
   logic [TAG_W-1:0]   wr_tag;
   logic               wr_hit;
   logic               unused_pc_lsb;

   assign rd_idx = PC[INDEX_W+1:2];
   assign rd_tag = PC[31:INDEX_W+2];
   assign wr_idx = upd_PC[INDEX_W+1:2];
   assign wr_tag = upd_PC[31:INDEX_W+2];
   assign unused_pc_lsb = ^{PC[1:0], upd_PC[1:0]};

   assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign taken   = hit && cnt_q[rd_idx][1];
   assign pred_PC = hit ? tgt_q[rd_idx] : 32'h0;
   assign wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            cnt_q[i]   <= 2'b01;
         end
      end else if (clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= 2'b01;
         end
      end else if (upd_valid) begin
         if (wr_hit) begin
            if (upd_taken) begin
               tgt_q[wr_idx] <= upd_target;
               if (cnt_q[wr_idx] != 2'b11)
                  cnt_q[wr_idx] <= cnt_q[wr_idx] + 2'd1;
            end else if (cnt_q[wr_idx] != 2'b00) begin
               cnt_q[wr_idx] <= cnt_q[wr_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            // Miss on a taken branch: allocate or evict the aliasing entry
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= upd_target;
            cnt_q[wr_idx]   <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         mis_q <= '0;
      else if (upd_valid && upd_mispred && (mis_q != {CNT_W{1'b1}}))
         mis_q <= mis_q + CNT_W'(1);
   end

   assign mispred_cnt = mis_q;

endmodule
